// File: rtl/image_write_queue_if.sv
// Pixel-write request side and VGA-facing word bus of the image write queue.
// The queue itself is the slave; the producer (CPU side) is the master.
interface image_write_queue_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [14:0] wr_addr;
   logic [7:0]  wr_color;
   logic        fill_start;
   logic [7:0]  fill_color;
   logic        busy;
   logic        overflow;
   logic [31:0] image_word;
   logic        io_device_id;

   modport master (
      output wr_valid, wr_addr, wr_color, fill_start, fill_color,
      input  wr_ready, busy, overflow, image_word, io_device_id
   );

   modport slave (
      input  wr_valid, wr_addr, wr_color, fill_start, fill_color,
      output wr_ready, busy, overflow, image_word, io_device_id
   );
endinterface

// File: rtl/image_write_queue.sv
// Buffers pixel writes and serialises them onto the VGA image_word bus with
// setup / strobe / release phases, plus a hardware screen-fill command.
module image_write_queue #(
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned SETUP_CYCLES   = 4,
   parameter int unsigned HOLD_CYCLES    = 8,
   parameter int unsigned RELEASE_CYCLES = 4,
   parameter int unsigned FILL_WORDS     = 16384
) (
   input logic                clock,
   input logic                reset,
   image_write_queue_if.slave bus
);

   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PtrOne   = {{AW{1'b0}}, 1'b1};
   localparam logic [14:0] FillLast = 15'(FILL_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StWrite, StRelease} state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [14:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;

   logic [AW:0] wptr_q, rptr_q;
   logic [14:0] mem_addr  [FIFO_DEPTH];
   logic [7:0]  mem_color [FIFO_DEPTH];
   logic        overflow_q;

   logic        fill_pending_q, fill_pending_d;
   logic        fill_active_q, fill_active_d;
   logic        fill_last_q, fill_last_d;
   logic [7:0]  fill_color_q, fill_color_d;
   logic [14:0] fill_addr_q, fill_addr_d;

   logic full, empty, ready, push, pop;
   logic try_load, use_fill;
   logic wen, io_idle;

   // Full is a function of registered pointers only, so a same-cycle pop never frees a slot.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign ready = !full && !fill_active_q && !fill_pending_q;
   assign push  = bus.wr_valid && ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + PtrOne;
         if (pop) rptr_q <= rptr_q + PtrOne;
         if (bus.wr_valid && !ready) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_addr[wptr_q[AW-1:0]]  <= bus.wr_addr;
         mem_color[wptr_q[AW-1:0]] <= bus.wr_color;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q         <= '0;
         data_q         <= '0;
         fill_pending_q <= 1'b0;
         fill_active_q  <= 1'b0;
         fill_last_q    <= 1'b0;
         fill_color_q   <= '0;
         fill_addr_q    <= '0;
      end else begin
         addr_q         <= addr_d;
         data_q         <= data_d;
         fill_pending_q <= fill_pending_d;
         fill_active_q  <= fill_active_d;
         fill_last_q    <= fill_last_d;
         fill_color_q   <= fill_color_d;
         fill_addr_q    <= fill_addr_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      addr_d         = addr_q;
      data_d         = data_q;
      fill_pending_d = fill_pending_q;
      fill_active_d  = fill_active_q;
      fill_last_d    = fill_last_q;
      fill_color_d   = fill_color_q;
      fill_addr_d    = fill_addr_q;
      pop            = 1'b0;
      try_load       = 1'b0;
      use_fill       = 1'b0;

      if (bus.fill_start && !fill_pending_q && !fill_active_q) begin
         fill_pending_d = 1'b1;
         fill_color_d   = bus.fill_color;
      end

      unique case (state_q)
         StIdle: try_load = 1'b1;
         StSetup: begin
            if (cnt_q == '0) begin
               state_d = StWrite;
               cnt_d   = 16'(HOLD_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StWrite: begin
            if (cnt_q == '0) begin
               state_d = StRelease;
               cnt_d   = 16'(RELEASE_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StRelease: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (fill_last_q) begin
               fill_active_d = 1'b0;
               fill_last_d   = 1'b0;
               fill_addr_d   = '0;
               state_d       = StIdle;
            end else begin
               try_load = 1'b1;
            end
         end
      endcase

      // A pending fill only starts from IDLE with an empty FIFO, so queued writes drain first.
      if (try_load) begin
         use_fill = fill_active_q || ((state_q == StIdle) && empty && fill_pending_q);
         state_d  = StSetup;
         cnt_d    = 16'(SETUP_CYCLES - 1);
         if (use_fill) begin
            fill_pending_d = 1'b0;
            fill_active_d  = 1'b1;
            addr_d         = fill_addr_q;
            data_d         = fill_color_q;
            fill_last_d    = (fill_addr_q == FillLast);
            if (fill_addr_q != FillLast) fill_addr_d = fill_addr_q + 15'd1;
         end else if (!empty) begin
            pop    = 1'b1;
            addr_d = mem_addr[rptr_q[AW-1:0]];
            data_d = mem_color[rptr_q[AW-1:0]];
         end else begin
            state_d = StIdle;
            cnt_d   = cnt_q;
         end
      end
   end

   always_comb begin
      wen     = 1'b0;
      io_idle = 1'b0;
      unique case (state_q)
         StIdle:    io_idle = 1'b1;
         StSetup:   wen = 1'b0;
         StWrite:   wen = 1'b1;
         StRelease: wen = 1'b0;
      endcase
   end

   assign bus.wr_ready     = ready;
   assign bus.overflow     = overflow_q;
   assign bus.busy         = (state_q != StIdle) || !empty || fill_pending_q || fill_active_q;
   assign bus.image_word   = {8'h00, wen, data_q, addr_q};
   assign bus.io_device_id = io_idle;

endmodule

// File: tb/tb_image_write_queue.sv
// Directed/randomised bench: a per-cycle trace of the VGA bus is compared with
// word sequences derived from the pushes and fill commands issued.
module tb_image_write_queue;
   localparam int unsigned S  = 4;
   localparam int unsigned H  = 8;
   localparam int unsigned R  = 4;
   localparam int unsigned W  = S + H + R;
   localparam int unsigned FW = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   image_write_queue_if bus ();

   image_write_queue #(
      .FIFO_DEPTH    (16),
      .SETUP_CYCLES  (S),
      .HOLD_CYCLES   (H),
      .RELEASE_CYCLES(R),
      .FILL_WORDS    (FW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   // {wr_ready, busy, io_device_id, image_word} sampled mid-cycle
   logic [34:0] trace[$];
   always @(negedge clock) trace.push_back({bus.wr_ready, bus.busy, bus.io_device_id, bus.image_word});

   int          checks = 0;
   int          errors = 0;
   logic [22:0] exp_q[$];
   int          gaps[$];
   int          bad;
   int          last_idx;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < limit) begin
         tick;
         n++;
      end
      chk("drain", 32'(n < limit), 32'd1);
   endtask

   // Each expected word must appear as S setup, H strobe, R release cycles; idle gaps recorded.
   task automatic scan(input int start);
      int          i;
      int          g;
      logic [32:0] e;
      i   = start;
      bad = 0;
      gaps.delete();
      foreach (exp_q[w]) begin
         g = 0;
         while (i < trace.size() && trace[i][32] == 1'b1) begin
            g++;
            i++;
         end
         gaps.push_back(g);
         for (int unsigned k = 0; k < W; k++) begin
            e = {1'b0, 8'h00, (k >= S && k < S + H), exp_q[w]};
            if (i >= trace.size() || trace[i][32:0] !== e) bad++;
            i++;
         end
      end
      last_idx = i - 1;
   endtask

   task automatic single_write(input string tag);
      int          st;
      int          nbad;
      logic [32:0] e;
      nbad = 0;
      tick;
      st = trace.size();
      chk({tag, " ready"}, 32'(bus.wr_ready), 32'd1);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 15'h1234;
      bus.wr_color = 8'hA5;
      tick;
      bus.wr_valid = 1'b0;
      repeat (20) tick;
      for (int k = 0; k < 19; k++) begin
         if (k < 2) e = {1'b1, 32'h0000_0000};
         else if (k < 6 || (k >= 14 && k < 18)) e = {1'b0, 32'h0052_9234};
         else if (k < 14) e = {1'b0, 32'h00D2_9234};
         else e = {1'b1, 32'h0052_9234};
         if (trace[st + k][32:0] !== e) nbad++;
      end
      chk({tag, " phases"}, 32'(nbad), 32'd0);
      chk({tag, " busy after"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int          st;
      int          idx_f;
      int          n;
      logic [14:0] a;
      logic [7:0]  c;

      bus.wr_valid   = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_color   = '0;
      bus.fill_start = 1'b0;
      bus.fill_color = '0;
      #1 reset = 1'b0;
      #11;
      chk("reset word", bus.image_word, 32'h0);
      chk("reset io", 32'(bus.io_device_id), 32'd1);
      chk("reset overflow", 32'(bus.overflow), 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick;
      chk("ready after reset", 32'(bus.wr_ready), 32'd1);

      single_write("t1");

      // Three queued random writes: back to back, no idle gap.
      st = trace.size();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         tick;
         a = 15'($urandom);
         c = 8'($urandom);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = a;
         bus.wr_color = c;
         exp_q.push_back({c, a});
      end
      tick;
      bus.wr_valid = 1'b0;
      drain(200);
      repeat (3) tick;
      scan(st);
      chk("t3 seq", 32'(bad), 32'd0);
      chk("t3 gaps", 32'(gaps[1] + gaps[2]), 32'd0);
      chk("t3 trail io", 32'(trace[last_idx + 1][32]), 32'd1);
      chk("t3 trail word", trace[last_idx + 1][31:0], {8'h00, 1'b0, exp_q[2]});

      // A, B, 15 idle cycles, then 17 pushes: the 17th meets a full FIFO as B's slot pops.
      st = trace.size();
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         tick;
         chk($sformatf("t2 ready pre%0d", i), 32'(bus.wr_ready), 32'd1);
         a = 15'($urandom);
         c = 8'($urandom);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = a;
         bus.wr_color = c;
         exp_q.push_back({c, a});
      end
      tick;
      bus.wr_valid = 1'b0;
      repeat (14) tick;
      for (int i = 0; i < 17; i++) begin
         tick;
         chk($sformatf("t2 ready %0d", i), 32'(bus.wr_ready), 32'(i < 16));
         a = 15'($urandom);
         c = 8'($urandom);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = a;
         bus.wr_color = c;
         if (i < 16) exp_q.push_back({c, a});
      end
      tick;
      bus.wr_valid = 1'b0;
      chk("t2 overflow", 32'(bus.overflow), 32'd1);
      drain(600);
      repeat (3) tick;
      chk("t2 overflow sticky", 32'(bus.overflow), 32'd1);
      scan(st);
      chk("t2 seq", 32'(bad), 32'd0);
      n = 0;
      for (int i = 1; i < gaps.size(); i++) n += gaps[i];
      chk("t2 gaps", 32'(n), 32'd0);

      tick;
      reset = 1'b0;
      #1;
      chk("t2 reset overflow", 32'(bus.overflow), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // Fill with two writes queued; fill_start shares a cycle with the second push.
      st = trace.size();
      exp_q.delete();
      tick;
      a = 15'($urandom);
      c = 8'($urandom);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_color = c;
      exp_q.push_back({c, a});
      tick;
      idx_f = trace.size();
      chk("t4 ready w2", 32'(bus.wr_ready), 32'd1);
      a = 15'($urandom);
      c = 8'($urandom);
      bus.wr_addr    = a;
      bus.wr_color   = c;
      bus.fill_start = 1'b1;
      bus.fill_color = 8'h3C;
      exp_q.push_back({c, a});
      tick;
      bus.wr_valid   = 1'b0;
      bus.fill_start = 1'b0;
      chk("t4 ready drop", 32'(bus.wr_ready), 32'd0);
      repeat (3) tick;
      bus.fill_start = 1'b1;
      bus.fill_color = 8'h55;
      tick;
      bus.fill_start = 1'b0;
      repeat (60) tick;
      chk("t4 busy mid", 32'(bus.busy), 32'd1);
      bus.fill_start = 1'b1;
      bus.fill_color = 8'h66;
      bus.wr_valid   = 1'b1;
      bus.wr_addr    = 15'($urandom);
      tick;
      bus.fill_start = 1'b0;
      bus.wr_valid   = 1'b0;
      chk("t4 overflow", 32'(bus.overflow), 32'd1);
      for (int i = 0; i < int'(FW); i++) exp_q.push_back({8'h3C, 15'(i)});
      drain(400);
      repeat (3) tick;
      scan(st);
      chk("t4 seq", 32'(bad), 32'd0);
      chk("t4 gap w", 32'(gaps[1]), 32'd0);
      chk("t4 gap fill", 32'(gaps[2] >= 1 && gaps[2] <= 2), 32'd1);
      n = 0;
      for (int i = 3; i < gaps.size(); i++) n += gaps[i];
      chk("t4 gaps fill", 32'(n), 32'd0);
      n = 0;
      for (int i = idx_f + 1; i <= last_idx; i++) if (trace[i][34] !== 1'b0) n++;
      chk("t4 ready low", 32'(n), 32'd0);
      chk("t4 busy last", 32'(trace[last_idx][33]), 32'd1);
      chk("t4 busy fall", 32'(trace[last_idx + 1][33]), 32'd0);
      chk("t4 ready rise", 32'(trace[last_idx + 1][34]), 32'd1);

      // Reset during the strobe abandons the write at once.
      tick;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 15'($urandom);
      bus.wr_color = 8'($urandom);
      tick;
      bus.wr_valid = 1'b0;
      repeat (6) tick;
      chk("t5 in write", 32'(bus.image_word[23]), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("t5 async word", bus.image_word, 32'h0);
      chk("t5 async io", 32'(bus.io_device_id), 32'd1);
      chk("t5 async busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick;
      chk("t5 ready", 32'(bus.wr_ready), 32'd1);
      chk("t5 busy", 32'(bus.busy), 32'd0);
      single_write("t5");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/image_write_queue.md
Name: image_write_queue

Overview:
- CPU-clock-domain producer for the VGA framebuffer write port.
- Accepts pixel writes (15-bit address, 8-bit palette index) and buffers them in a FIFO.
- Serialises each write into the 32-bit image_word bus plus the io_device_id qualifier that the VGA block synchronises into VGA_clk.
- Stretches each write into setup / strobe / release phases so the slower or asynchronous VGA_clk samples a stable word. Also provides a hardware screen-fill command.

Parameters:
- FIFO_DEPTH, 16, pixel-write FIFO entries; power of two, >= 2.
- SETUP_CYCLES, 4, clocks address/data are driven with wEn=0 before the strobe; >= 1.
- HOLD_CYCLES, 8, clocks wEn=1 is held; >= 1.
- RELEASE_CYCLES, 4, clocks address/data stay held with wEn=0 after the strobe; >= 1.
- FILL_WORDS, 16384, number of addresses written by a fill (0..FILL_WORDS-1).

Ports:
- clock  in  1  processor clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  FIFO can accept; equals !full && !fill_active && !fill_pending.
- wr_addr  in  15  framebuffer address.
- wr_color  in  8  palette index.
- fill_start  in  1  one-cycle pulse: fill the entire framebuffer.
- fill_color  in  8  palette index for the fill; sampled with fill_start.
- busy  out  1  high when the FSM is not IDLE, FIFO is non-empty, or a fill is pending/active.
- overflow  out  1  sticky: a wr_valid was presented while wr_ready=0.
- image_word  out  32  [31:24]=0, [23]=wEn, [22:15]=data, [14:0]=addr.
- io_device_id  out  1  1 = VGA hold (idle), 0 = word in transit.

Behaviour:
- Reset (asynchronous, reset=0):
  - FIFO emptied; FSM to IDLE; fill state cleared.
  - image_word=0; io_device_id=1; overflow=0; busy=0.
  - wr_ready=1 after release.
  - An in-flight write is abandoned; wEn drops immediately.
- FIFO:
  - Push when wr_valid && wr_ready.
  - A push while the FIFO is full is refused even if a pop occurs in the same cycle, because full is registered.
  - Refused wr_valid sets overflow until reset; the data is dropped.
- FSM states: IDLE, SETUP, WRITE, RELEASE. Each non-IDLE state lasts exactly its parameter count of cycles (down-counter).
  - IDLE: if a fill is active, load the next fill word; else if the FIFO is non-empty, pop the head. Next state is SETUP. Otherwise stay in IDLE.
  - SETUP: addr/data driven, wEn=0, io_device_id=0.
  - WRITE: wEn=1, addr/data unchanged.
  - RELEASE: wEn=0, addr/data unchanged. On its last cycle, go directly to SETUP with the next word if work remains, else to IDLE.
  - In IDLE: io_device_id=1; image_word retains the last addr/data with wEn=0.
- Latency and throughput:
  - Push accepted in cycle t; FIFO non-empty at t+1; IDLE pops at t+1; SETUP visible on image_word at t+2.
  - Back-to-back words take SETUP_CYCLES+HOLD_CYCLES+RELEASE_CYCLES clocks each with no IDLE gap (16 clocks at defaults).
  - addr/data change only on the SETUP entry edge, never while wEn=1.
- Fill:
  - fill_start sets fill_pending and latches fill_color; wr_ready drops the next cycle.
  - Pending becomes active when the FSM is IDLE and the FIFO is empty, so queued writes drain first.
  - Active fill issues addresses 0,1,...,FILL_WORDS-1 with fill_color, using the same phase sequence.
  - fill_start while a fill is pending or active is ignored.
  - After the last address's RELEASE: fill cleared, FSM returns to IDLE, wr_ready rises.
  - The fill address counter is 15 bits and does not wrap past FILL_WORDS-1.
- Simultaneous events:
  - wr_valid and fill_start in the same cycle: the write is accepted if wr_ready=1 and executes before the fill.
  - fill_start and reset: reset wins.

Test Plan:
- Reset then a single push addr=0x1234, color=0xA5 → at t+2 image_word=0x0052_9234 (wEn=0) for 4 clocks, then 0x00D2_9234 for 8, then 0x0052_9234 for 4; io_device_id=0 for all 16 clocks, then 1.
- 17 pushes on consecutive cycles (default depth) → exactly 16 accepted; wr_ready falls; overflow=1 and remains 1; all 16 words appear in order, spaced 16 clocks apart.
- Three queued writes → wEn pulses are exactly 8 clocks each; addr never changes while wEn=1; no IDLE cycle between words.
- fill_start with fill_color=0x3C and FILL_WORDS=8 (test override) while 2 writes are queued → 2 writes first, then addresses 0..7 with data 0x3C; wr_ready=0 throughout; busy falls 1 cycle after the final RELEASE.
- Assert reset during the WRITE phase → image_word=0 and io_device_id=1 asynchronously; after release, busy=0, FIFO empty, the next push behaves as in the first scenario.
